// File: rtl/dff_bank_write_arbiter.sv
// Round-robin write arbiter that owns one shared enable-gated flip-flop bank.
// Each grant runs four states: arbitrate, present data, write, verify readback.
module dff_bank_write_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] din,
   output logic [N_REQ-1:0]       gnt,
   output logic [N_REQ-1:0]       ack,
   output logic [WIDTH-1:0]       bank_d,
   output logic                   bank_en,
   input  logic [WIDTH-1:0]       bank_q,
   input  logic                   err_clr,
   output logic                   busy,
   output logic                   err
);

   localparam int PTR_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_WRITE = 2'd2,
      S_CHECK = 2'd3
   } state_t;

   // First set request at or above the pointer, wrapping past N_REQ-1 back to 0.
   function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] pick;
      logic             found;
      int               idx;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(p) + i) % N_REQ;
         if (!found && r[idx[PTR_W-1:0]]) begin
            found = 1'b1;
            pick  = idx[PTR_W-1:0];
         end
      end
      return pick;
   endfunction

   function automatic logic [WIDTH-1:0] din_slice(input logic [N_REQ*WIDTH-1:0] d,
                                                  input logic [PTR_W-1:0] sel);
      logic [WIDTH-1:0] s;
      s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (PTR_W'(i) == sel) begin
            s = d[i*WIDTH +: WIDTH];
         end
      end
      return s;
   endfunction

   state_t           r_state;
   state_t           w_state_nxt;
   logic [N_REQ-1:0] r_gnt;
   logic [N_REQ-1:0] w_gnt_nxt;
   logic [N_REQ-1:0] r_ack;
   logic [N_REQ-1:0] w_ack_nxt;
   logic [WIDTH-1:0] r_bank_d;
   logic [WIDTH-1:0] w_bank_d_nxt;
   logic             r_bank_en;
   logic             w_bank_en_nxt;
   logic [WIDTH-1:0] r_hold;
   logic [WIDTH-1:0] w_hold_nxt;
   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_ptr_nxt;
   logic [PTR_W-1:0] r_widx;
   logic [PTR_W-1:0] w_widx_nxt;
   logic             r_err;
   logic             w_err_nxt;
   logic             r_busy;
   logic             w_busy_nxt;
   logic             w_any;
   logic [PTR_W-1:0] w_win;
   logic [WIDTH-1:0] w_din_sel;
   logic             w_mismatch;

   assign w_any      = |req;
   assign w_win      = rr_pick(req, r_ptr);
   assign w_din_sel  = din_slice(din, w_win);
   assign w_mismatch = (r_state == S_CHECK) && (bank_q != r_hold);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: only IDLE waits, every other state lasts one cycle.
   always_comb begin
      w_state_nxt = S_IDLE;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_nxt = S_GRANT;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_GRANT: w_state_nxt = S_WRITE;
         S_WRITE: w_state_nxt = S_CHECK;
         S_CHECK: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output/datapath next values; everything is registered in the block below.
   always_comb begin
      w_gnt_nxt     = r_gnt;
      w_ack_nxt     = r_ack;
      w_bank_d_nxt  = r_bank_d;
      w_bank_en_nxt = r_bank_en;
      w_hold_nxt    = r_hold;
      w_ptr_nxt     = r_ptr;
      w_widx_nxt    = r_widx;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_gnt_nxt  = N_REQ'(1) << w_win;
               w_hold_nxt = w_din_sel;
               w_widx_nxt = w_win;
            end else begin
               w_gnt_nxt  = '0;
            end
         end
         S_GRANT: begin
            w_bank_d_nxt  = r_hold;
            w_bank_en_nxt = 1'b1;
         end
         S_WRITE: begin
            w_bank_en_nxt = 1'b0;
            w_ack_nxt     = r_gnt;
         end
         S_CHECK: begin
            w_gnt_nxt = '0;
            w_ack_nxt = '0;
            if (r_widx == PTR_W'(N_REQ - 1)) begin
               w_ptr_nxt = '0;
            end else begin
               w_ptr_nxt = r_widx + PTR_W'(1);
            end
         end
         default: begin
            w_gnt_nxt     = '0;
            w_ack_nxt     = '0;
            w_bank_en_nxt = 1'b0;
         end
      endcase

      // A clear in the same cycle as a mismatch wins.
      if (err_clr) begin
         w_err_nxt = 1'b0;
      end else if (w_mismatch) begin
         w_err_nxt = 1'b1;
      end else begin
         w_err_nxt = r_err;
      end

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   // Registered outputs and datapath; reset drops bank_en without an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gnt     <= '0;
         r_ack     <= '0;
         r_bank_d  <= '0;
         r_bank_en <= 1'b0;
         r_hold    <= '0;
         r_ptr     <= '0;
         r_widx    <= '0;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_gnt     <= w_gnt_nxt;
         r_ack     <= w_ack_nxt;
         r_bank_d  <= w_bank_d_nxt;
         r_bank_en <= w_bank_en_nxt;
         r_hold    <= w_hold_nxt;
         r_ptr     <= w_ptr_nxt;
         r_widx    <= w_widx_nxt;
         r_err     <= w_err_nxt;
         r_busy    <= w_busy_nxt;
      end
   end

   assign gnt     = r_gnt;
   assign ack     = r_ack;
   assign bank_d  = r_bank_d;
   assign bank_en = r_bank_en;
   assign busy    = r_busy;
   assign err     = r_err;

endmodule
